rom_mp: RTL and testbench

- Parametrised multi-port ROM for the dual-issue fetch path; successor to the single-port combinational ROM.
- Provides NUM_PORTS independent read channels, each with a valid/ready request, a registered 1-cycle read and a 2-entry response queue that absorbs backpressure.
- Includes a program port so boot code can be loaded after reset.
- Out-of-range addresses return zero with an error flag.

---
 rtl/rom_mp_pkg.sv | 15 +
 rtl/rom_rsp_queue.sv | 81 ++++++++
 rtl/rom_mp.sv | 66 ++++++
 tb/tb_rom_mp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_mp_pkg.sv
// Shared definitions for the multi-port fetch ROM: queue depth, occupancy
// type and the address range check used by both program and read paths.
package rom_mp_pkg;

   localparam int RSP_DEPTH = 2;

   // Occupancy counts 0..RSP_DEPTH inclusive.
   typedef logic [$clog2(RSP_DEPTH + 1)-1:0] occ_t;

   // Addresses are widened to 32 bits so one helper serves any ADDR_WIDTH.
   function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned data_num);
      return addr < data_num;
   endfunction

endpackage

// File: rtl/rom_rsp_queue.sv
// Two-entry response FIFO for one read port. Entry 0 is always the head and
// drives the outputs directly, so data is registered and stays put while
// the consumer stalls; when the queue empties the head keeps its last value.
module rom_rsp_queue
   import rom_mp_pkg::*;
#(
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  srst_n,
   input  logic                  accept_en,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  push_err,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_err
);

   typedef struct packed {
      logic                  err;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t q0, q1, q0_n, q1_n, din;
   occ_t   occ, occ_n;
   logic   push, pop;

   assign din        = {push_err, push_data};
   assign pop_valid  = (occ != '0);
   assign pop        = pop_valid & pop_ready;
   // A full queue can still take a new entry in the cycle its head leaves.
   assign push_ready = accept_en & ((occ < occ_t'(RSP_DEPTH)) | pop);
   assign push       = push_valid & push_ready;
   assign pop_data   = q0.data;
   assign pop_err    = q0.err;

   // Next-state: shift toward the head on pop, write the new entry behind
   // whatever remains.
   always_comb begin
      q0_n  = q0;
      q1_n  = q1;
      occ_n = occ;
      case ({push, pop})
         2'b10: begin
            if (occ == '0) q0_n = din;
            else           q1_n = din;
            occ_n = occ + occ_t'(1);
         end
         2'b01: begin
            if (occ == occ_t'(2)) q0_n = q1;
            occ_n = occ - occ_t'(1);
         end
         2'b11: begin
            if (occ == occ_t'(1)) begin
               q0_n = din;
            end else begin
               q0_n = q1;
               q1_n = din;
            end
         end
         default: ;
      endcase
   end

   // Queue registers; reset drops queued responses and zeroes the outputs.
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         q0  <= '0;
         q1  <= '0;
         occ <= '0;
      end else begin
         q0  <= q0_n;
         q1  <= q1_n;
         occ <= occ_n;
      end
   end

endmodule

// File: rtl/rom_mp.sv
// Multi-port programmable ROM for the dual-issue fetch path. One shared word
// array, a program write port, and per-port registered reads feeding a
// small response queue that absorbs consumer backpressure.
module rom_mp
   import rom_mp_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int DATA_NUM   = 1024,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_PORTS  = 2
) (
   input  logic                             clk,
   input  logic                             srst_n,
   input  logic                             prog_en,
   input  logic [ADDR_WIDTH-1:0]            prog_addr,
   input  logic [DATA_WIDTH-1:0]            prog_wdata,
   input  logic [NUM_PORTS-1:0]             rd_req_valid,
   output logic [NUM_PORTS-1:0]             rd_req_ready,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
   output logic [NUM_PORTS-1:0]             rd_rsp_valid,
   input  logic [NUM_PORTS-1:0]             rd_rsp_ready,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  rd_rdata,
   output logic [NUM_PORTS-1:0]             rd_err
);

   logic [DATA_WIDTH-1:0] mem [DATA_NUM];
   logic                  accept_en;

   // Reads are refused during reset and while boot code is being written,
   // which removes any same-cycle read/write collision on the array.
   assign accept_en = srst_n & ~prog_en;

   // Program write; contents survive reset, out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (prog_en && addr_in_range(32'(prog_addr), DATA_NUM)) begin
         mem[prog_addr] <= prog_wdata;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [ADDR_WIDTH-1:0] addr;
      logic                  in_range;
      logic [DATA_WIDTH-1:0] word;

      assign addr     = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      assign in_range = addr_in_range(32'(addr), DATA_NUM);
      assign word     = in_range ? mem[addr] : '0;

      rom_rsp_queue #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_rsp_queue (
         .clk        (clk),
         .srst_n     (srst_n),
         .accept_en  (accept_en),
         .push_valid (rd_req_valid[p]),
         .push_ready (rd_req_ready[p]),
         .push_data  (word),
         .push_err   (~in_range),
         .pop_valid  (rd_rsp_valid[p]),
         .pop_ready  (rd_rsp_ready[p]),
         .pop_data   (rd_rdata[p*DATA_WIDTH +: DATA_WIDTH]),
         .pop_err    (rd_err[p])
      );
   end

endmodule

// File: tb/tb_rom_mp.sv
// Bench for rom_mp with a non-power-of-two depth so both sides of the range
// boundary are addressable.
module tb_rom_mp;

   localparam int DW = 64;
   localparam int DN = 1000;
   localparam int AW = 10;
   localparam int NP = 2;

   logic              clk = 1'b0;
   logic              srst_n = 1'b0;
   logic              prog_en = 1'b0;
   logic [AW-1:0]     prog_addr = '0;
   logic [DW-1:0]     prog_wdata = '0;
   logic [NP-1:0]     rd_req_valid = '0;
   logic [NP-1:0]     rd_req_ready;
   logic [NP*AW-1:0]  rd_addr = '0;
   logic [NP-1:0]     rd_rsp_valid;
   logic [NP-1:0]     rd_rsp_ready = '0;
   logic [NP*DW-1:0]  rd_rdata;
   logic [NP-1:0]     rd_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic          err;
      logic [DW-1:0] data;
   } ent_t;

   logic [DW-1:0] mem_model [int];
   ent_t          exp_q [NP][$];
   ent_t          last_head [NP];

   rom_mp #(
      .DATA_WIDTH (DW),
      .DATA_NUM   (DN),
      .ADDR_WIDTH (AW),
      .NUM_PORTS  (NP)
   ) dut (
      .clk          (clk),
      .srst_n       (srst_n),
      .prog_en      (prog_en),
      .prog_addr    (prog_addr),
      .prog_wdata   (prog_wdata),
      .rd_req_valid (rd_req_valid),
      .rd_req_ready (rd_req_ready),
      .rd_addr      (rd_addr),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rdata     (rd_rdata),
      .rd_err       (rd_err)
   );

   always #5 clk = ~clk;

   function automatic ent_t lookup(int a);
      ent_t e;
      if (a >= DN) begin
         e.err  = 1'b1;
         e.data = '0;
      end else begin
         e.err  = 1'b0;
         e.data = mem_model.exists(a) ? mem_model[a] : '0;
      end
      return e;
   endfunction

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] port_data(int p);
      return rd_rdata[p*DW +: DW];
   endfunction

   // Reference model: each port is a plain FIFO of {err,data} fed from a
   // sparse memory image, updated from the inputs present at each edge.
   always @(posedge clk) begin
      if (!srst_n) begin
         for (int p = 0; p < NP; p++) begin
            exp_q[p].delete();
            last_head[p] = '{err: 1'b0, data: '0};
         end
      end else begin
         for (int p = 0; p < NP; p++) begin
            logic m_pop, m_rdy, m_push;
            ent_t e;
            m_pop  = (exp_q[p].size() > 0) && rd_rsp_ready[p];
            m_rdy  = !prog_en && ((exp_q[p].size() < 2) || m_pop);
            m_push = rd_req_valid[p] && m_rdy;
            e      = lookup(int'(rd_addr[p*AW +: AW]));
            if (m_pop)  void'(exp_q[p].pop_front());
            if (m_push) exp_q[p].push_back(e);
            if (exp_q[p].size() > 0) last_head[p] = exp_q[p][0];
         end
         if (prog_en && (int'(prog_addr) < DN)) mem_model[int'(prog_addr)] = prog_wdata;
      end
   end

   // Compare every port against the model on each falling edge.
   always @(negedge clk) begin
      for (int p = 0; p < NP; p++) begin
         logic exp_rdy;
         ent_t cur;
         exp_rdy = srst_n && !prog_en &&
                   ((exp_q[p].size() < 2) || ((exp_q[p].size() > 0) && rd_rsp_ready[p]));
         cur = (exp_q[p].size() > 0) ? exp_q[p][0] : last_head[p];
         check($sformatf("p%0d req_ready", p), 64'(rd_req_ready[p]), 64'(exp_rdy));
         check($sformatf("p%0d rsp_valid", p), 64'(rd_rsp_valid[p]), 64'(exp_q[p].size() > 0));
         check($sformatf("p%0d rdata", p), port_data(p), cur.data);
         check($sformatf("p%0d err", p), 64'(rd_err[p]), 64'(cur.err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(int a, logic [DW-1:0] d);
      prog_en    = 1'b1;
      prog_addr  = a[AW-1:0];
      prog_wdata = d;
      tick();
      prog_en    = 1'b0;
   endtask

   task automatic set_addr(int p, int a);
      rd_addr[p*AW +: AW] = a[AW-1:0];
   endtask

   initial begin
      // Reset
      repeat (2) tick();
      check("reset req_ready", 64'(rd_req_ready), 64'd0);
      check("reset rsp_valid", 64'(rd_rsp_valid), 64'd0);
      srst_n = 1'b1;

      // Boot image
      for (int i = 0; i < 8; i++) prog(i, 64'h1000 + 64'(i));
      prog(999, 64'hAAAA_5555_0000_0999);
      prog(1000, 64'hFFFF_FFFF_FFFF_FFFF);
      prog(5, 64'hDEAD_BEEF);

      // Single read, one-cycle latency
      rd_rsp_ready    = '1;
      rd_req_valid[0] = 1'b1;
      set_addr(0, 5);
      #1 check("t1 ready", 64'(rd_req_ready[0]), 64'd1);
      tick();
      rd_req_valid[0] = 1'b0;
      check("t1 valid", 64'(rd_rsp_valid[0]), 64'd1);
      check("t1 data", port_data(0), 64'hDEAD_BEEF);
      check("t1 err", 64'(rd_err[0]), 64'd0);
      tick();

      // Streaming on port0, same-address reads on port1
      rd_req_valid = 2'b11;
      set_addr(1, 3);
      for (int i = 0; i < 4; i++) begin
         set_addr(0, i);
         tick();
         if (i == 0) begin
            check("t2 p0 first", port_data(0), 64'h1000);
            check("t2 p1 first", port_data(1), 64'h1003);
         end
      end
      rd_req_valid = '0;
      tick();

      // Backpressure on port0
      rd_rsp_ready[0] = 1'b0;
      rd_req_valid[0] = 1'b1;
      set_addr(0, 1);
      tick();
      set_addr(0, 2);
      tick();
      set_addr(0, 3);
      #1;
      check("t3 full ready", 64'(rd_req_ready[0]), 64'd0);
      check("t3 head", port_data(0), 64'h1001);
      repeat (2) tick();
      rd_rsp_ready[0] = 1'b1;
      #1 check("t3 pop ready", 64'(rd_req_ready[0]), 64'd1);
      tick();
      rd_req_valid[0] = 1'b0;
      check("t3 second", port_data(0), 64'h1002);
      repeat (3) tick();

      // Range boundary on port1
      rd_req_valid[1] = 1'b1;
      set_addr(1, 999);
      tick();
      set_addr(1, 1000);
      check("t4 last data", port_data(1), 64'hAAAA_5555_0000_0999);
      check("t4 last err", 64'(rd_err[1]), 64'd0);
      tick();
      rd_req_valid[1] = 1'b0;
      check("t4 oor data", port_data(1), 64'd0);
      check("t4 oor err", 64'(rd_err[1]), 64'd1);
      tick();

      // Programming while responses drain
      rd_rsp_ready[0] = 1'b0;
      rd_req_valid[0] = 1'b1;
      set_addr(0, 6);
      tick();
      set_addr(0, 7);
      tick();
      rd_req_valid    = 2'b11;
      set_addr(0, 6);
      set_addr(1, 2);
      rd_rsp_ready[0] = 1'b1;
      prog_en         = 1'b1;
      prog_addr       = 10'd6;
      prog_wdata      = 64'hCAFE_F00D;
      for (int k = 0; k < 3; k++) begin
         #1 check("t5 ready blocked", 64'(rd_req_ready), 64'd0);
         tick();
         if (k == 0) check("t5 drain", port_data(0), 64'h1007);
      end
      prog_en         = 1'b0;
      rd_req_valid[1] = 1'b0;
      tick();
      rd_req_valid[0] = 1'b0;
      check("t5 new data", port_data(0), 64'hCAFE_F00D);
      tick();

      // Reset with a full queue; memory survives
      rd_rsp_ready[0] = 1'b0;
      rd_req_valid[0] = 1'b1;
      set_addr(0, 5);
      tick();
      tick();
      rd_req_valid[0] = 1'b0;
      srst_n = 1'b0;
      tick();
      check("t6 valid", 64'(rd_rsp_valid[0]), 64'd0);
      check("t6 data", port_data(0), 64'd0);
      check("t6 err", 64'(rd_err[0]), 64'd0);
      srst_n          = 1'b1;
      rd_rsp_ready[0] = 1'b1;
      rd_req_valid[0] = 1'b1;
      tick();
      rd_req_valid[0] = 1'b0;
      check("t6 kept valid", 64'(rd_rsp_valid[0]), 64'd1);
      check("t6 kept data", port_data(0), 64'hDEAD_BEEF);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
